// File: rtl/alu_result_display_pkg.sv
// Shared board-output definitions: active-low 7-segment patterns, BCD conversion FSM states
// and small combinational helpers used by the ALU result display.
package alu_result_display_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the next shift.
    function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = adj[4*i +: 4];
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/alu_result_display_bin2bcd_dd.sv
// Sequential signed binary to sign + 3-digit BCD converter (double dabble).
// The sign/bcd outputs are the display registers and only change as a complete result.
module bin2bcd_dd
    import alu_result_display_pkg::*;
#(
    parameter int N = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [N-1:0] din,
    output logic                done,
    output logic                loading,
    output logic                sign,
    output logic [11:0]         bcd
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    conv_state_t state_r;
    logic [N-1:0] mag_r;
    logic [11:0]  work_r;
    logic [3:0]   cnt_r;
    logic         sign_work_r;
    logic         sign_r;
    logic [11:0]  bcd_r;

    logic [N-1:0] din_u_s;
    logic [N-1:0] mag_s;
    logic [11:0]  adj_s;

    // Magnitude of the input as unsigned N bits, so the most negative value maps cleanly.
    always_comb begin
        din_u_s = $unsigned(din);
        if (din_u_s[N-1]) begin
            mag_s = ~din_u_s + ONE;
        end else begin
            mag_s = din_u_s;
        end
        adj_s = dd_adjust(work_r);
    end

    // Conversion FSM and shift datapath; reset aborts and shows +0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mag_r       <= '0;
            work_r      <= 12'd0;
            cnt_r       <= 4'd0;
            sign_work_r <= 1'b0;
            sign_r      <= 1'b0;
            bcd_r       <= 12'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    sign_work_r <= din_u_s[N-1];
                    mag_r       <= mag_s;
                    work_r      <= 12'd0;
                    cnt_r       <= 4'(N);
                    state_r     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    work_r <= {adj_s[10:0], mag_r[N-1]};
                    mag_r  <= {mag_r[N-2:0], 1'b0};
                    cnt_r  <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    sign_r  <= sign_work_r;
                    bcd_r   <= work_r;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign done    = (state_r == ST_DONE);
    assign loading = (state_r == ST_LOAD);
    assign sign    = sign_r;
    assign bcd     = bcd_r;

endmodule

// File: rtl/alu_result_display.sv
// Shows the registered signed ALU result on the 4-digit 7-segment display:
// sign, hundreds, tens, units, with overflow on the units decimal point and zero on a LED.
module alu_result_display
    import alu_result_display_pkg::*;
#(
    parameter int N           = 5,
    parameter int REFRESH_DIV = 17
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [N-1:0] i_alu_Result,
    input  logic         i_overflow_Flag,
    input  logic         i_zero_Flag,
    output logic [6:0]   o_seg,
    output logic [3:0]   o_an,
    output logic         o_dp,
    output logic         o_led_zero
);

    logic [N-1:0]             res_r;
    logic                     ovf_r;
    logic                     zero_r;
    logic [N-1:0]             last_conv_r;
    logic                     pending_r;
    logic [REFRESH_DIV-1:0]   refresh_cnt_r;
    logic [6:0]               seg_r;
    logic [3:0]               an_r;
    logic                     dp_r;

    logic        start_s;
    logic        done_s;
    logic        loading_s;
    logic        sign_s;
    logic [11:0] bcd_s;
    logic [1:0]  sel_s;
    logic [3:0]  hund_s;
    logic [3:0]  tens_s;
    logic [3:0]  units_s;
    logic [6:0]  seg_s;
    logic [3:0]  an_s;
    logic        dp_s;

    // Input capture of the ALU result and flags.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            res_r  <= '0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            res_r  <= i_alu_Result;
            ovf_r  <= i_overflow_Flag;
            zero_r <= i_zero_Flag;
        end
    end

    // Change detect: remembers the value handed to the converter; reset forces one conversion.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            last_conv_r <= '0;
            pending_r   <= 1'b1;
        end else begin
            if (loading_s) begin
                last_conv_r <= res_r;
            end
            if (done_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    assign start_s = pending_r || (res_r != last_conv_r);

    bin2bcd_dd #(.N(N)) u_conv (
        .clk     (i_clock),
        .rst     (i_reset),
        .start   (start_s),
        .din     (res_r),
        .done    (done_s),
        .loading (loading_s),
        .sign    (sign_s),
        .bcd     (bcd_s)
    );

    // Free-running refresh counter; its top two bits select the active digit.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            refresh_cnt_r <= '0;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + {{(REFRESH_DIV-1){1'b0}}, 1'b1};
        end
    end

    // Digit mux with leading-zero blanking.
    always_comb begin
        sel_s   = refresh_cnt_r[REFRESH_DIV-1 -: 2];
        hund_s  = bcd_s[11:8];
        tens_s  = bcd_s[7:4];
        units_s = bcd_s[3:0];
        seg_s   = SEG_BLANK;
        an_s    = 4'b1111;
        dp_s    = 1'b1;
        case (sel_s)
            2'd3: begin
                an_s = 4'b0111;
                if (sign_s) begin
                    seg_s = SEG_MINUS;
                end else begin
                    seg_s = SEG_BLANK;
                end
            end
            2'd2: begin
                an_s = 4'b1011;
                if (hund_s == 4'd0) begin
                    seg_s = SEG_BLANK;
                end else begin
                    seg_s = seg_decode(hund_s);
                end
            end
            2'd1: begin
                an_s = 4'b1101;
                if ((tens_s == 4'd0) && (hund_s == 4'd0)) begin
                    seg_s = SEG_BLANK;
                end else begin
                    seg_s = seg_decode(tens_s);
                end
            end
            2'd0: begin
                an_s  = 4'b1110;
                seg_s = seg_decode(units_s);
                dp_s  = ~ovf_r;
            end
            default: begin
                an_s  = 4'b1111;
                seg_s = SEG_BLANK;
                dp_s  = 1'b1;
            end
        endcase
    end

    // Registered display drive.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            seg_r <= SEG_BLANK;
            an_r  <= 4'b1111;
            dp_r  <= 1'b1;
        end else begin
            seg_r <= seg_s;
            an_r  <= an_s;
            dp_r  <= dp_s;
        end
    end

    assign o_seg      = seg_r;
    assign o_an       = an_r;
    assign o_dp       = dp_r;
    assign o_led_zero = zero_r;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with a short refresh period so each scan covers all four digits.
module tb_alu_result_display;

    localparam int N           = 5;
    localparam int REFRESH_DIV = 4;
    localparam int PERIOD      = 16;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SM = 7'b0111111;

    logic         clk;
    logic         rst;
    logic [N-1:0] res;
    logic         ovf;
    logic         zero;
    logic [6:0]   seg;
    logic [3:0]   an;
    logic         dp;
    logic         led_zero;

    int checks;
    int errors;

    logic [6:0] slot_seg [4];
    logic       slot_dp  [4];

    alu_result_display #(.N(N), .REFRESH_DIV(REFRESH_DIV)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_alu_Result    (res),
        .i_overflow_Flag (ovf),
        .i_zero_Flag     (zero),
        .o_seg           (seg),
        .o_an            (an),
        .o_dp            (dp),
        .o_led_zero      (led_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Record what each anode slot shows over one full refresh period; unseen slots stay X.
    task automatic scan();
        for (int i = 0; i < 4; i++) begin
            slot_seg[i] = 7'bxxxxxxx;
            slot_dp[i]  = 1'bx;
        end
        for (int c = 0; c < PERIOD; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin slot_seg[0] = seg; slot_dp[0] = dp; end
                4'b1101: begin slot_seg[1] = seg; slot_dp[1] = dp; end
                4'b1011: begin slot_seg[2] = seg; slot_dp[2] = dp; end
                4'b0111: begin slot_seg[3] = seg; slot_dp[3] = dp; end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        logic [6:0] exp_seg [4];
        rst = 1'b1; res = 5'd0; ovf = 1'b0; zero = 1'b0;
        wait_cycles(3);
        checks++;
        if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b expected 1111", an); end
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h expected 7f", seg); end
        checks++;
        if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b expected 1", dp); end
        checks++;
        if (led_zero !== 1'b0) begin errors++; $display("FAIL reset_led got %b expected 0", led_zero); end
        rst = 1'b0;
        wait_cycles(N + 5);
        scan();
        exp_seg = '{S0, SB, SB, SB};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (slot_seg[i] !== exp_seg[i]) begin
                errors++;
                $display("FAIL reset_zero slot%0d seg got %h expected %h", i, slot_seg[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_positive();
        logic [6:0] exp_seg [4];
        res = 5'sd13; ovf = 1'b0; zero = 1'b0;
        wait_cycles(N + 6);
        scan();
        exp_seg = '{S3, S1, SB, SB};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (slot_seg[i] !== exp_seg[i]) begin
                errors++;
                $display("FAIL pos13 slot%0d seg got %h expected %h", i, slot_seg[i], exp_seg[i]);
            end
            checks++;
            if (slot_dp[i] !== 1'b1) begin
                errors++;
                $display("FAIL pos13_dp slot%0d got %b expected 1", i, slot_dp[i]);
            end
        end
    endtask

    task automatic test_neg_overflow();
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4];
        res = 5'b10000; ovf = 1'b1; zero = 1'b0;
        wait_cycles(N + 6);
        scan();
        exp_seg = '{S6, S1, SB, SM};
        exp_dp  = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (slot_seg[i] !== exp_seg[i]) begin
                errors++;
                $display("FAIL neg16 slot%0d seg got %h expected %h", i, slot_seg[i], exp_seg[i]);
            end
            checks++;
            if (slot_dp[i] !== exp_dp[i]) begin
                errors++;
                $display("FAIL neg16_dp slot%0d got %b expected %b", i, slot_dp[i], exp_dp[i]);
            end
        end
    endtask

    task automatic test_neg_one_then_zero();
        logic [6:0] exp_seg [4];
        res = 5'b11111; ovf = 1'b0; zero = 1'b0;
        wait_cycles(N + 6);
        scan();
        exp_seg = '{S1, SB, SB, SM};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (slot_seg[i] !== exp_seg[i]) begin
                errors++;
                $display("FAIL neg1 slot%0d seg got %h expected %h", i, slot_seg[i], exp_seg[i]);
            end
        end
        res = 5'd0; zero = 1'b1;
        checks++;
        if (led_zero !== 1'b0) begin errors++; $display("FAIL led_before got %b expected 0", led_zero); end
        @(negedge clk);
        checks++;
        if (led_zero !== 1'b1) begin errors++; $display("FAIL led_zero got %b expected 1", led_zero); end
        wait_cycles(N + 5);
        scan();
        exp_seg = '{S0, SB, SB, SB};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (slot_seg[i] !== exp_seg[i]) begin
                errors++;
                $display("FAIL zero slot%0d seg got %h expected %h", i, slot_seg[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_seg [4];
        zero = 1'b0; ovf = 1'b0;
        res = 5'd3;
        wait_cycles(2);
        res = 5'd9;
        wait_cycles(2 * (N + 3) + 4);
        exp_seg = '{S9, SB, SB, SB};
        for (int pass = 0; pass < 2; pass++) begin
            scan();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (slot_seg[i] !== exp_seg[i]) begin
                    errors++;
                    $display("FAIL b2b_pass%0d slot%0d seg got %h expected %h", pass, i, slot_seg[i], exp_seg[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [6:0] exp_seg [4];
        res = 5'd12;
        wait_cycles(4);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'b1111) begin errors++; $display("FAIL midrst_an got %b expected 1111", an); end
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL midrst_seg got %h expected 7f", seg); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'b1110) begin errors++; $display("FAIL midrst_plus0_an got %b expected 1110", an); end
        checks++;
        if (seg !== S0) begin errors++; $display("FAIL midrst_plus0_seg got %h expected %h", seg, S0); end
        wait_cycles(N + 4);
        scan();
        exp_seg = '{S2, S1, SB, SB};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (slot_seg[i] !== exp_seg[i]) begin
                errors++;
                $display("FAIL midrst_12 slot%0d seg got %h expected %h", i, slot_seg[i], exp_seg[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; res = 5'd0; ovf = 1'b0; zero = 1'b0;
        test_reset();
        test_positive();
        test_neg_overflow();
        test_neg_one_then_zero();
        test_back_to_back();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
